// File: rtl/sawtooth_phase_decoder_pkg.sv
// Shared sawtooth sample format and lock-state encoding, common with the waveform generator.
package sawtooth_phase_decoder_pkg;
  localparam int SAMPLE_W = 16;
  localparam int PHASE_W  = 10;
  localparam int FRAC_W   = 6;

  typedef enum logic [1:0] {
    LK_EMPTY,
    LK_ACQUIRE,
    LK_LOCKED
  } lock_state_e;

  typedef struct packed {
    logic [PHASE_W-1:0] phase;
    logic [FRAC_W-1:0]  frac;
  } sample_t;
endpackage

// File: rtl/sawtooth_phase_decoder_period_counter.sv
// Wrap-to-wrap period measurement; the partial period before the first wrap is never reported.
module sawtooth_period_counter #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                accept,
  input  logic                wrap,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);
  logic [PERIOD_W-1:0] count;
  logic                seen_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      seen_wrap    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (accept) begin
        if (wrap) begin
          // The wrap sample starts the next period, so it reloads to 1 rather than 0.
          count     <= PERIOD_W'(1);
          seen_wrap <= 1'b1;
          if (seen_wrap) begin
            period       <= count;
            period_valid <= 1'b1;
          end
        end else if (count != '1) begin
          count <= count + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/sawtooth_phase_decoder.sv
// Recovers phase, increment, wrap and period from a sawtooth sample stream and tracks increment lock.
module sawtooth_phase_decoder
  import sawtooth_phase_decoder_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int PERIOD_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                phase_valid,
  output logic [PHASE_W-1:0]  phase,
  output logic [PHASE_W-1:0]  phase_inc,
  output logic                wrap,
  output logic                fmt_err,
  output logic                period_valid,
  output logic [PERIOD_W-1:0] period,
  output logic                locked
);
  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  // Capture stage: the edge that takes sample_valid registers the sample here.
  logic    in_vld;
  sample_t in_smp;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_vld <= 1'b0;
      in_smp <= '0;
    end else begin
      in_vld <= sample_valid;
      if (sample_valid) in_smp <= sample;
    end
  end

  lock_state_e        state, state_n;
  logic [PHASE_W-1:0] prev_phase, ref_inc, ref_inc_n;
  logic [CNT_W-1:0]   match_cnt, match_cnt_n;
  logic               ref_vld, ref_vld_n;

  logic [PHASE_W-1:0] cur_phase, inc_raw, dec_inc;
  logic               dec_wrap, inc_match;

  always_comb begin
    cur_phase   = in_smp.phase;
    inc_raw     = cur_phase - prev_phase;
    dec_inc     = (state == LK_EMPTY) ? '0 : inc_raw;
    dec_wrap    = (state != LK_EMPTY) && (cur_phase < prev_phase);
    inc_match   = (inc_raw == ref_inc) && (inc_raw != '0);
    state_n     = state;
    ref_inc_n   = ref_inc;
    match_cnt_n = match_cnt;
    ref_vld_n   = ref_vld;
    if (in_vld) begin
      unique case (state)
        LK_EMPTY: begin
          state_n     = LK_ACQUIRE;
          match_cnt_n = '0;
          ref_vld_n   = 1'b0;
        end
        LK_ACQUIRE: begin
          if (ref_vld && inc_match) begin
            if (match_cnt == CNT_W'(LOCK_COUNT - 1)) state_n = LK_LOCKED;
            match_cnt_n = match_cnt + 1'b1;
          end else begin
            ref_inc_n   = inc_raw;
            ref_vld_n   = 1'b1;
            match_cnt_n = '0;
          end
        end
        LK_LOCKED: begin
          if (!inc_match) begin
            state_n     = LK_ACQUIRE;
            ref_inc_n   = inc_raw;
            match_cnt_n = '0;
          end
        end
        default: state_n = LK_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LK_EMPTY;
      prev_phase <= '0;
      ref_inc    <= '0;
      match_cnt  <= '0;
      ref_vld    <= 1'b0;
    end else begin
      state     <= state_n;
      ref_inc   <= ref_inc_n;
      match_cnt <= match_cnt_n;
      ref_vld   <= ref_vld_n;
      if (in_vld) prev_phase <= cur_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
      fmt_err     <= 1'b0;
      phase       <= '0;
      phase_inc   <= '0;
      locked      <= 1'b0;
    end else begin
      phase_valid <= in_vld;
      wrap        <= in_vld && dec_wrap;
      fmt_err     <= in_vld && (in_smp.frac != '0);
      if (in_vld) begin
        phase     <= cur_phase;
        phase_inc <= dec_inc;
        locked    <= (state_n == LK_LOCKED);
      end
    end
  end

  sawtooth_period_counter #(.PERIOD_W(PERIOD_W)) u_period (
    .clk          (clk),
    .reset        (reset),
    .accept       (in_vld),
    .wrap         (dec_wrap),
    .period       (period),
    .period_valid (period_valid)
  );
endmodule
